// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Contents: control opcodes resolved inside fetch (CALL/RET/HALT), byte-field
// positions of the 32-bit instruction word, the fetch FSM state type and the
// stack fault codes reported on fault_code.
package fetch_pkg;

  // Control opcodes, compared against op[5:0] (op[7:6] carry IMM flags).
  localparam logic [5:0] OP_CALL = 6'h30;
  localparam logic [5:0] OP_RET  = 6'h31;
  localparam logic [5:0] OP_HALT = 6'h32;

  // Instruction byte fields: OP = [7:0], ARG1 = [15:8], ARG2 = [23:16], DEST = [31:24].
  localparam int unsigned OP_LSB   = 0;
  localparam int unsigned ARG1_LSB = 8;
  localparam int unsigned ARG2_LSB = 16;
  localparam int unsigned DEST_LSB = 24;
  localparam int unsigned FIELD_W  = 8;
  localparam int unsigned OPC_W    = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_HALTED
  } state_e;

  typedef enum logic [1:0] {
    FAULT_NONE = 2'b00,
    FAULT_OVF  = 2'b01,
    FAULT_UNF  = 2'b10
  } fault_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, the program ROM and the execute stage.
//   address       : ROM read address (driven by fetch)
//   opcode        : registered ROM output (driven by ROM)
//   instr         : instruction handed to execute (driven by fetch)
//   instr_valid   : instr presented (driven by fetch)
//   instr_ready   : execute accepts instr (driven by execute)
//   branch_valid  : redirect request, meaningful with the accept (driven by execute)
//   branch_target : redirect address (driven by execute)
// master = fetch side, slave = ROM/execute side.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 32
);
  logic [ADDR_W-1:0]  address;
  logic [INSTR_W-1:0] opcode;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               branch_valid;
  logic [ADDR_W-1:0]  branch_target;

  modport master (
    output address,
    input  opcode,
    output instr,
    output instr_valid,
    input  instr_ready,
    input  branch_valid,
    input  branch_target
  );

  modport slave (
    input  address,
    output opcode,
    input  instr,
    input  instr_valid,
    output instr_ready,
    output branch_valid,
    output branch_target
  );
endinterface

// File: rtl/fetch_unit_call_stack.sv
// Return-address LIFO for CALL/RET.
// Ports:
//   clk, rst    : clock, synchronous active-low reset (empties the stack)
//   clear_i     : synchronous empty (edit mode)
//   push_i      : push data_i (ignored when full)
//   pop_i       : drop the top entry (ignored when empty)
//   data_i      : value to push
//   top_o       : current top entry (undefined when empty)
//   full_o      : DEPTH entries held
//   empty_o     : no entries held
// Entry contents are never reset; only the stack pointer is meaningful.
module call_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned SP_W  = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SP_W-1:0]  sp_q, sp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] wr_idx, top_idx;

  assign full_o  = (sp_q == SP_W'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign wr_idx  = IDX_W'(sp_q);
  assign top_idx = IDX_W'(sp_q - SP_W'(1));
  assign top_o   = mem_q[top_idx];

  always_comb begin
    sp_d = sp_q;
    if (clear_i) begin
      sp_d = '0;
    end else if (push_i && !full_o) begin
      sp_d = sp_q + SP_W'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !clear_i && push_i && !full_o) begin
      mem_q[wr_idx] <= data_i;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage downstream of the program ROM.
// Owns the PC, drives the ROM address, resolves CALL/RET/HALT internally via
// a return-address stack and hands all other instructions to execute over a
// valid/ready handshake, accepting branch redirects with the accept.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   edit       : programming mode, returns to IDLE and clears PC/stack/fault
//   start      : begins execution from IDLE
//   bus        : ROM and execute handshake signals (fetch_unit_if.master)
//   pc         : current program counter
//   halted     : HALTED state
//   fault      : stack fault latched
//   fault_code : 01 overflow, 10 underflow, 00 none
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned INSTR_W     = 32,
  parameter int unsigned PC_STEP     = 4,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              edit,
  input  logic              start,
  fetch_unit_if.master      bus,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fault,
  output logic [1:0]        fault_code
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  fault_e            code_q, code_d;

  logic              stk_clear, stk_push, stk_pop, stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_top, ret_addr;

  logic [OPC_W-1:0]   op;
  logic [FIELD_W-1:0] arg1;

  assign op       = bus.opcode[OP_LSB +: OPC_W];
  assign arg1     = bus.opcode[ARG1_LSB +: FIELD_W];
  assign ret_addr = pc_q + ADDR_W'(PC_STEP);

  call_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .clear_i (stk_clear),
    .push_i  (stk_push),
    .pop_i   (stk_pop),
    .data_i  (ret_addr),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    fault_d         = fault_q;
    code_d          = code_q;
    stk_clear       = 1'b0;
    stk_push        = 1'b0;
    stk_pop         = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_ISSUE;
      ST_ISSUE: begin
        // The ROM output is stable here because the PC is held since FETCH,
        // so instr can be driven straight from opcode while backpressured.
        unique case (op)
          OP_CALL: begin
            if (stk_full) begin
              fault_d = 1'b1;
              code_d  = FAULT_OVF;
              state_d = ST_HALTED;
            end else begin
              stk_push = 1'b1;
              pc_d     = ADDR_W'(arg1);
              state_d  = ST_FETCH;
            end
          end
          OP_RET: begin
            if (stk_empty) begin
              fault_d = 1'b1;
              code_d  = FAULT_UNF;
              state_d = ST_HALTED;
            end else begin
              stk_pop = 1'b1;
              pc_d    = stk_top;
              state_d = ST_FETCH;
            end
          end
          OP_HALT: state_d = ST_HALTED;
          default: begin
            bus.instr_valid = 1'b1;
            bus.instr       = bus.opcode;
            if (bus.instr_ready) begin
              pc_d    = bus.branch_valid ? bus.branch_target : ret_addr;
              state_d = ST_FETCH;
            end
          end
        endcase
      end
      ST_HALTED: ;
      default: state_d = ST_IDLE;
    endcase

    // Edit overrides every transition computed above.
    if (edit) begin
      state_d   = ST_IDLE;
      pc_d      = ADDR_W'(RESET_PC);
      fault_d   = 1'b0;
      code_d    = FAULT_NONE;
      stk_clear = 1'b1;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= ADDR_W'(RESET_PC);
      fault_q <= 1'b0;
      code_q  <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  assign bus.address = pc_q;
  assign pc          = pc_q;
  assign halted      = (state_q == ST_HALTED);
  assign fault       = fault_q;
  assign fault_code  = code_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a registered 256-entry ROM model.
module tb_fetch_unit;
  logic       clk = 1'b0;
  logic       rst, edit, start;
  logic [7:0] pc;
  logic       halted, fault;
  logic [1:0] fault_code;

  logic [31:0] rom [256];
  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit_if #(.ADDR_W(8), .INSTR_W(32)) bus ();

  fetch_unit #(
    .ADDR_W      (8),
    .INSTR_W     (32),
    .PC_STEP     (4),
    .STACK_DEPTH (4),
    .RESET_PC    (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .edit       (edit),
    .start      (start),
    .bus        (bus),
    .pc         (pc),
    .halted     (halted),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  // Registered ROM: opcode reflects the address of the previous cycle.
  always @(posedge clk) bus.opcode <= rom[bus.address];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
  endtask

  task automatic do_edit();
    edit = 1'b1;
    step();
    edit = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; edit = 1'b0; start = 1'b0;
    bus.instr_ready = 1'b0; bus.branch_valid = 1'b0; bus.branch_target = 8'h00;
    clear_rom();
    step(); step();
    chk("rst_addr",  32'(bus.address), 32'h00);
    chk("rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_halt",  32'(halted), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_code",  32'(fault_code), 32'h0);
    rst = 1'b1;

    // start while editing is ignored
    edit = 1'b1; start = 1'b1;
    step();
    edit = 1'b0; start = 1'b0;
    step(); step(); step();
    chk("edit_start_valid", 32'(bus.instr_valid), 32'h0);
    chk("edit_start_pc",    32'(pc), 32'h00);

    // straight line, backpressure, branch
    rom[8'h00] = 32'h0A0B0C01;
    rom[8'h04] = 32'h0D0E0F02;
    rom[8'h14] = 32'h00000003;
    bus.instr_ready = 1'b1;
    do_start();                                          // c1 FETCH
    chk("sl_c1_valid", 32'(bus.instr_valid), 32'h0);
    step();                                              // c2 ISSUE
    chk("sl_c2_valid", 32'(bus.instr_valid), 32'h1);
    chk("sl_c2_instr", bus.instr, 32'h0A0B0C01);
    step();                                              // c3
    chk("sl_c3_addr",  32'(bus.address), 32'h04);
    chk("sl_c3_valid", 32'(bus.instr_valid), 32'h0);
    step();                                              // c4
    chk("sl_c4_valid", 32'(bus.instr_valid), 32'h1);
    chk("sl_c4_instr", bus.instr, 32'h0D0E0F02);
    bus.instr_ready = 1'b0;
    bus.branch_valid = 1'b1;                             // without ready: ignored
    bus.branch_target = 8'h14;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) bus.branch_valid = 1'b0;
      chk("bp_valid", 32'(bus.instr_valid), 32'h1);
      chk("bp_instr", bus.instr, 32'h0D0E0F02);
      chk("bp_pc",    32'(pc), 32'h04);
    end
    bus.instr_ready = 1'b1;
    bus.branch_valid = 1'b1;
    step();
    bus.branch_valid = 1'b0;
    chk("br_addr",  32'(bus.address), 32'h14);
    chk("br_valid", 32'(bus.instr_valid), 32'h0);
    step();
    chk("br_instr", bus.instr, 32'h00000003);
    do_edit();
    chk("edit1_pc",   32'(pc), 32'h00);
    chk("edit1_halt", 32'(halted), 32'h0);

    // CALL (with IMM flag bit in op) and RET
    clear_rom();
    rom[8'h00] = 32'h00000001;
    rom[8'h04] = 32'h11000001;
    rom[8'h08] = 32'h00002070;
    rom[8'h0C] = 32'h22000005;
    rom[8'h20] = 32'h00000031;
    do_start();
    step(); step(); step(); step();                      // c5 FETCH @8
    step();                                              // c6 ISSUE CALL
    chk("call_valid", 32'(bus.instr_valid), 32'h0);
    chk("call_pc",    32'(pc), 32'h08);
    step();
    chk("call_addr",  32'(bus.address), 32'h20);
    step();                                              // c8 ISSUE RET
    chk("ret_valid",  32'(bus.instr_valid), 32'h0);
    step();
    chk("ret_addr",   32'(bus.address), 32'h0C);
    step();
    chk("ret_valid2", 32'(bus.instr_valid), 32'h1);
    chk("ret_instr",  bus.instr, 32'h22000005);
    do_edit();

    // stack overflow: five nested CALLs
    clear_rom();
    rom[8'h00] = 32'h00001030;
    rom[8'h10] = 32'h00002030;
    rom[8'h20] = 32'h00003030;
    rom[8'h30] = 32'h00004030;
    rom[8'h40] = 32'h00005030;
    do_start();
    for (int i = 0; i < 9; i++) step();                  // c10 ISSUE 5th CALL
    chk("ovf_c10_halt", 32'(halted), 32'h0);
    chk("ovf_c10_pc",   32'(pc), 32'h40);
    step();
    chk("ovf_halt",  32'(halted), 32'h1);
    chk("ovf_fault", 32'(fault), 32'h1);
    chk("ovf_code",  32'(fault_code), 32'h1);
    chk("ovf_pc",    32'(pc), 32'h40);
    do_edit();
    chk("edit_fault", 32'(fault), 32'h0);
    chk("edit_code",  32'(fault_code), 32'h0);
    chk("edit_halt",  32'(halted), 32'h0);

    // stack underflow: RET on empty stack
    clear_rom();
    rom[8'h00] = 32'h00000031;
    do_start();
    step(); step();
    chk("unf_halt",  32'(halted), 32'h1);
    chk("unf_fault", 32'(fault), 32'h1);
    chk("unf_code",  32'(fault_code), 32'h2);
    chk("unf_valid", 32'(bus.instr_valid), 32'h0);
    do_edit();

    // PC wrap at 252
    clear_rom();
    rom[8'h00] = 32'h00000001;
    rom[8'hFC] = 32'h44000002;
    do_start();
    step();                                              // c2 ISSUE @0
    bus.branch_valid = 1'b1;
    bus.branch_target = 8'hFC;
    step();
    bus.branch_valid = 1'b0;
    chk("wrap_br_addr", 32'(bus.address), 32'hFC);
    step();
    chk("wrap_instr", bus.instr, 32'h44000002);
    step();
    chk("wrap_addr", 32'(bus.address), 32'h00);
    step();
    chk("wrap_instr2", bus.instr, 32'h00000001);
    do_edit();

    // HALT, start ignored, edit exits
    clear_rom();
    rom[8'h00] = 32'h00000032;
    do_start();
    step();
    chk("halt_valid", 32'(bus.instr_valid), 32'h0);
    chk("halt_c2",    32'(halted), 32'h0);
    step();
    chk("halt_c3",    32'(halted), 32'h1);
    chk("halt_fault", 32'(fault), 32'h0);
    do_start();
    step(); step();
    chk("halt_start", 32'(halted), 32'h1);
    chk("halt_valid2", 32'(bus.instr_valid), 32'h0);
    do_edit();
    chk("halt_edit",    32'(halted), 32'h0);
    chk("halt_edit_pc", 32'(pc), 32'h00);

    // reset overrides start
    rst = 1'b0; start = 1'b1;
    step();
    rst = 1'b1; start = 1'b0;
    step(); step();
    chk("rst_over_valid", 32'(bus.instr_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
